// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : Run controller for up to eight CPU cores. On a start request it
//            holds the cores in reset for RESET_CYCLES cycles, releases them,
//            then watches each core for an explicit halt or a stalled PC.
//            The run ends with done when every core has finished, or with
//            timeout when the RUN cycle budget (MAX_CYCLES) is exhausted.
// Ports    : clk         - sole clock, rising edge
//            reset       - asynchronous active-high reset
//            start       - single-cycle (re)start request (IDLE / DONE only)
//            pc          - packed core PCs, core i at [i*PC_WIDTH +: PC_WIDTH]
//            halt        - per-core explicit halt
//            core_reset  - active-high reset to each core
//            running     - high while in RUN
//            finished    - sticky per-core completion flags
//            done        - all cores finished within budget
//            timeout     - budget exhausted before all cores finished
//            cycle_count - RUN cycles elapsed, saturating at MAX_CYCLES
// Config   : RUN_CTRL_STAGGER_EN - when defined, core i is released i cycles
//            after core 0; otherwise all cores are released together.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
  parameter int NUM_CORES    = 1,
  parameter int PC_WIDTH     = 32,
  parameter int RESET_CYCLES = 5,
  parameter int MAX_CYCLES   = 50,
  parameter int STALL_LIMIT  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_CORES*PC_WIDTH-1:0] pc,
  input  logic [NUM_CORES-1:0]          halt,
  output logic [NUM_CORES-1:0]          core_reset,
  output logic                          running,
  output logic [NUM_CORES-1:0]          finished,
  output logic                          done,
  output logic                          timeout,
  output logic [31:0]                   cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RESET_HOLD = 2'd1,
    S_RUN        = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  localparam int C_HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int C_STALL_W = $clog2(STALL_LIMIT + 1);

  localparam logic [C_HOLD_W-1:0]  C_HOLD_LAST = C_HOLD_W'(RESET_CYCLES - 1);
  localparam logic [C_STALL_W-1:0] C_STALL_LIM = C_STALL_W'(STALL_LIMIT);
  localparam logic [31:0]          C_MAX       = 32'(MAX_CYCLES);
  localparam logic [31:0]          C_LAST      = 32'(MAX_CYCLES - 1);

  state_t                 state_q;
  logic [C_HOLD_W-1:0]    hold_q;
  logic [NUM_CORES-1:0]   core_reset_q;
  logic [NUM_CORES-1:0]   rel_d;
  logic                   running_q;
  logic [NUM_CORES-1:0]   finished_q;
  logic [NUM_CORES-1:0]   finished_d;
  logic                   done_q;
  logic                   timeout_q;
  logic [31:0]            count_q;

  // Per-core PC tracking. seen_q marks that the previous-PC register holds a
  // valid sample, i.e. the core's first released cycle has already passed.
  logic [NUM_CORES-1:0]   seen_q;
  logic [NUM_CORES-1:0]   seen_d;
  logic [PC_WIDTH-1:0]    pc_core [NUM_CORES];
  logic [PC_WIDTH-1:0]    prev_q  [NUM_CORES];
  logic [PC_WIDTH-1:0]    prev_d  [NUM_CORES];
  logic [C_STALL_W-1:0]   stall_q [NUM_CORES];
  logic [C_STALL_W-1:0]   stall_d [NUM_CORES];

  logic                   all_fin_q;
  logic                   all_fin_d;

  generate
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_pc_split
      assign pc_core[g] = pc[g*PC_WIDTH +: PC_WIDTH];
    end
  endgenerate

  // Release pattern on entering RUN and its evolution while the cores run.
  // Staggered: a zero walks up from core 0, one core per cycle.
`ifdef RUN_CTRL_STAGGER_EN
  localparam logic [NUM_CORES-1:0] C_REL_FIRST = {NUM_CORES{1'b1}} << 1;
  assign rel_d = core_reset_q << 1;
`else
  localparam logic [NUM_CORES-1:0] C_REL_FIRST = '0;
  assign rel_d = '0;
`endif

  // Per-core completion detection; only released, unfinished cores in RUN
  // update, so a finished core's tracking state freezes.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      seen_d[i]     = seen_q[i];
      prev_d[i]     = prev_q[i];
      stall_d[i]    = stall_q[i];
      finished_d[i] = finished_q[i];
      if (state_q == S_RUN && !core_reset_q[i] && !finished_q[i]) begin
        seen_d[i] = 1'b1;
        prev_d[i] = pc_core[i];
        if (seen_q[i]) begin
          if (pc_core[i] == prev_q[i]) begin
            if (stall_q[i] != C_STALL_LIM) begin
              stall_d[i] = stall_q[i] + 1'b1;
            end
          end else begin
            stall_d[i] = '0;
          end
        end
        if (halt[i] || (stall_d[i] == C_STALL_LIM)) begin
          finished_d[i] = 1'b1;
        end
      end
    end
  end

  assign all_fin_q = &finished_q;
  assign all_fin_d = &finished_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      core_reset_q <= '1;
      running_q    <= 1'b0;
      finished_q   <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
      seen_q       <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        prev_q[i]  <= '0;
        stall_q[i] <= '0;
      end
    end else begin
      finished_q <= finished_d;
      seen_q     <= seen_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        prev_q[i]  <= prev_d[i];
        stall_q[i] <= stall_d[i];
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (state_q == S_DONE) begin
            core_reset_q <= rel_d;
          end
          if (start) begin
            state_q      <= S_RESET_HOLD;
            hold_q       <= '0;
            core_reset_q <= '1;
            running_q    <= 1'b0;
            finished_q   <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
            seen_q       <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
              stall_q[i] <= '0;
            end
          end
        end

        S_RESET_HOLD: begin
          if (hold_q == C_HOLD_LAST) begin
            state_q      <= S_RUN;
            running_q    <= 1'b1;
            core_reset_q <= C_REL_FIRST;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end

        S_RUN: begin
          core_reset_q <= rel_d;
          if (all_fin_q) begin
            state_q   <= S_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (count_q == C_LAST) begin
            // Budget spent this cycle. If the last core completes on this
            // same edge, stay in RUN one more cycle so completion wins.
            count_q <= C_MAX;
            if (!all_fin_d) begin
              state_q   <= S_DONE;
              running_q <= 1'b0;
              timeout_q <= 1'b1;
            end
          end else if (count_q != C_MAX) begin
            count_q <= count_q + 32'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign core_reset  = core_reset_q;
  assign running     = running_q;
  assign finished    = finished_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = count_q;

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 1: number of CPU cores controlled (1..8).
REQ-002 SHALL have parameter PC_WIDTH, default 32: width of each core PC input.
REQ-003 SHALL have parameter RESET_CYCLES, default 5: cycles core reset is held after start (>=1).
REQ-004 SHALL have parameter MAX_CYCLES, default 50: RUN cycle budget before timeout (>=2).
REQ-005 SHALL have parameter STALL_LIMIT, default 4: consecutive unchanged-PC cycles that mark a core finished (>=1).
REQ-006 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  single-cycle request to (re)start a run.
REQ-009 SHALL have port pc  input  NUM_CORES*PC_WIDTH  core PCs, core i in bits [i*PC_WIDTH +: PC_WIDTH].
REQ-010 SHALL have port halt  input  NUM_CORES  per-core explicit halt indication.
REQ-011 SHALL have port core_reset  output  NUM_CORES  active-high reset driven to each core.
REQ-012 SHALL have port running  output  1  high while in RUN.
REQ-013 SHALL have port finished  output  NUM_CORES  sticky per-core completion flags.
REQ-014 SHALL have port done  output  1  all cores finished within budget.
REQ-015 SHALL have port timeout  output  1  budget exhausted before all cores finished.
REQ-016 SHALL have port cycle_count  output  32  RUN cycles elapsed, saturating at MAX_CYCLES.

Function
REQ-017 SHALL implement FSM IDLE, RESET_HOLD, RUN, DONE; clk and reset only, no other clocks.
REQ-018 IDLE: core_reset all ones, running 0; start=1 -> RESET_HOLD next cycle; start ignored in RESET_HOLD and RUN.
REQ-019 RESET_HOLD: core_reset all ones for exactly RESET_CYCLES cycles, then -> RUN; finished, done, timeout, cycle_count cleared on entry.
REQ-020 RUN: core_reset deasserts on first RUN cycle; cycle_count 0 in first RUN cycle, +1 per subsequent cycle.
REQ-021 Per core, a registered previous PC SHALL be loaded in the core's first released cycle; stall counter increments each later cycle pc equals previous PC, clears to 0 on any change.
REQ-022 finished[i] SHALL set (sticky) the cycle after halt[i] sampled 1 or stall counter reaches STALL_LIMIT; no further updates for that core.
REQ-023 RUN -> DONE with done=1 the cycle after all finished bits are 1.
REQ-024 RUN -> DONE with timeout=1 when cycle_count reaches MAX_CYCLES-1 with any finished bit 0; cycle_count then holds MAX_CYCLES.
REQ-025 Simultaneous completion and budget exhaustion SHALL yield done=1, timeout=0; done and timeout never both 1.
REQ-026 DONE: cores stay released, outputs held; start=1 -> RESET_HOLD (restart).
REQ-027 Counters SHALL saturate, never wrap; PC compare is full PC_WIDTH equality.

Reset
REQ-028 reset=1 SHALL immediately force IDLE: core_reset all ones, running 0, finished 0, done 0, timeout 0, cycle_count 0, stall counters 0.
REQ-029 Reset asserted mid-RUN SHALL abort the run with no done/timeout pulse; start honoured the first cycle after reset falls.

Configuration
REQ-030 Macro RUN_CTRL_STAGGER_EN defined: core i released i cycles after core 0; its PC tracking and halt sampling start at its own release; cycle_count and budget based on core 0 release.
REQ-031 Macro RUN_CTRL_STAGGER_EN undefined: all cores released in the same cycle; no stagger logic synthesised.

Verification
REQ-032 Defaults, start pulse -> core_reset high 5 cycles, running high on cycle 6, cycle_count 0 then increments.
REQ-033 NUM_CORES=1, pc increments 4 per cycle then holds 0x3000_0010 -> finished[0] after 4 equal cycles, done=1, timeout=0.
REQ-034 NUM_CORES=2, core 1 pc never stalls, halt 0 -> timeout=1 at cycle_count 50, finished=2'b01, done=0.
REQ-035 halt[1] and last stall on same cycle as cycle_count=49 -> done=1, timeout=0.
REQ-036 reset pulse mid-RUN at cycle_count 10 -> outputs at reset values immediately; new start rerun from RESET_HOLD.
REQ-037 RUN_CTRL_STAGGER_EN, NUM_CORES=4 -> core_reset falls on cores 0..3 in four consecutive cycles.
